dmux4way_rr_sched: RTL and testbench

DMUX4WAY_RR_SCHED -- requirements
Module: dmux4way_rr_sched

---
 rtl/dmux4way_rr_sched.sv | 141 ++++++++++++++
 tb/tb_dmux4way_rr_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux4way_rr_sched.sv
// Single-slot holding register that broadcasts its payload to four channels in strict
// round-robin order. Optional per-channel enable mask via `DMUX4WAY_RR_SCHED_MASK_EN.
module dmux4way_rr_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       select,
  output logic [7:0]       count
`ifdef DMUX4WAY_RR_SCHED_MASK_EN
  ,
  input  logic [3:0]       en_mask
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         sel_q, sel_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [3:0]         valid_q, valid_d;

  logic [3:0]         en_s;
  logic               sel_en_s;
  logic               dn_hs_s;
  logic               up_hs_s;
  logic               in_ready_s;

`ifdef DMUX4WAY_RR_SCHED_MASK_EN
  assign en_s = en_mask;
`else
  assign en_s = 4'b1111;
`endif

  // First enabled channel strictly after cur, cyclically; cur itself if no other is enabled.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] nxt;
    logic [1:0] cand;
    nxt = cur;
    for (int k = 3; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (en[cand]) begin
        nxt = cand;
      end else begin
        nxt = nxt;
      end
    end
    return nxt;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign sel_en_s   = en_s[sel_q];
  assign dn_hs_s    = (state_q == ST_FULL) && sel_en_s && out_ready[sel_q];
  // in_ready passes the downstream handshake through so back-to-back transfers never bubble.
  assign in_ready_s = reset_n && ((state_q == ST_EMPTY) || dn_hs_s);
  assign up_hs_s    = in_valid && in_ready_s;

  // Next-state computation for holding register, pointer, counter and channel valid.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    if (dn_hs_s) begin
      sel_d = next_enabled(sel_q, en_s);
      cnt_d = cnt_q + 8'd1;
    end else if ((state_q == ST_FULL) && !sel_en_s) begin
      sel_d = next_enabled(sel_q, en_s);
    end else begin
      sel_d = sel_q;
    end

    case (state_q)
      ST_EMPTY: begin
        if (up_hs_s) begin
          state_d = ST_FULL;
          data_d  = in_data;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (up_hs_s) begin
          state_d = ST_FULL;
          data_d  = in_data;
        end else if (dn_hs_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (state_d == ST_FULL) begin
      valid_d = onehot(sel_d);
    end else begin
      valid_d = 4'b0000;
    end
  end

  // State registers with asynchronous clear; a held payload is simply dropped on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= 2'b00;
      cnt_q   <= 8'h00;
      valid_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = data_q;
  assign out_valid = valid_q & en_s;
  assign select    = sel_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_dmux4way_rr_sched.sv
// Directed self-checking bench for dmux4way_rr_sched; inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_dmux4way_rr_sched;

  logic        clock;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  select;
  logic [7:0]  count;
`ifdef DMUX4WAY_RR_SCHED_MASK_EN
  logic [3:0]  en_mask;
`endif

  int n_vec;
  int n_err;

  dmux4way_rr_sched #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .select    (select),
    .count     (count)
`ifdef DMUX4WAY_RR_SCHED_MASK_EN
    ,
    .en_mask   (en_mask)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    #2;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rst_out_valid: got %b want 0000", out_valid); end
    n_vec++; if (select !== 2'b00) begin n_err++; $display("FAIL rst_select: got %0d want 0", select); end
    n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
    n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_in_order();
    logic [15:0] exp_d;
    logic [1:0]  exp_s;
    out_ready = 4'b1111;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clock);
      if (i < 4) begin
        in_valid = 1'b1;
        in_data  = 16'hA000 + 16'(i);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        exp_d = 16'hA000 + 16'(i - 1);
        exp_s = 2'(i - 1);
        n_vec++; if (out_valid !== (4'b0001 << exp_s)) begin n_err++; $display("FAIL order_valid[%0d]: got %b want %b", i, out_valid, 4'b0001 << exp_s); end
        n_vec++; if (out_data !== exp_d) begin n_err++; $display("FAIL order_data[%0d]: got %h want %h", i, out_data, exp_d); end
        n_vec++; if (select !== exp_s) begin n_err++; $display("FAIL order_select[%0d]: got %0d want %0d", i, select, exp_s); end
      end
      @(posedge clock);
    end
    @(negedge clock);
    #1;
    n_vec++; if (count !== 8'd4) begin n_err++; $display("FAIL order_count: got %0d want 4", count); end
    n_vec++; if (select !== 2'b00) begin n_err++; $display("FAIL order_select_end: got %0d want 0", select); end
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL order_valid_end: got %b want 0000", out_valid); end
  endtask

  task automatic test_stall();
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = 16'hB000;
    out_ready = 4'b1111;
    @(posedge clock);
    @(negedge clock);
    in_data   = 16'hB001;
    out_ready = 4'b1101;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_passthru_ready: got %b want 1", in_ready); end
    @(posedge clock);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 16'hC000 + 16'(i);
      #1;
      n_vec++; if (out_valid !== 4'b0010) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 0010", i, out_valid); end
      n_vec++; if (out_data !== 16'hB001) begin n_err++; $display("FAIL stall_data[%0d]: got %h want b001", i, out_data); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_vec++; if (count !== 8'd5) begin n_err++; $display("FAIL stall_count[%0d]: got %0d want 5", i, count); end
      n_vec++; if (select !== 2'd1) begin n_err++; $display("FAIL stall_select[%0d]: got %0d want 1", i, select); end
      @(posedge clock);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_vec++; if (count !== 8'd6) begin n_err++; $display("FAIL stall_count_end: got %0d want 6", count); end
    n_vec++; if (select !== 2'd2) begin n_err++; $display("FAIL stall_select_end: got %0d want 2", select); end
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL stall_valid_end: got %b want 0000", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    logic [1:0]  exp_s;
    logic [7:0]  exp_c;
    out_ready = 4'b1111;
    for (int i = 0; i <= 260; i++) begin
      @(negedge clock);
      if (i < 260) begin
        in_valid = 1'b1;
        in_data  = 16'hD000 + 16'(i);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        exp_d = 16'hD000 + 16'(i - 1);
        exp_s = 2'((2 + i - 1) % 4);
        exp_c = 8'((6 + i - 1) % 256);
        n_vec++; if (out_valid !== (4'b0001 << exp_s)) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, 4'b0001 << exp_s); end
        n_vec++; if (out_data !== exp_d) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, exp_d); end
        n_vec++; if (count !== exp_c) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, count, exp_c); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      end
      @(posedge clock);
    end
    @(negedge clock);
    #1;
    n_vec++; if (count !== 8'd10) begin n_err++; $display("FAIL b2b_count_wrap: got %0d want 10", count); end
    n_vec++; if (select !== 2'd2) begin n_err++; $display("FAIL b2b_select_end: got %0d want 2", select); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = 16'hE000;
    out_ready = 4'b0000;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL arst_pre_valid: got %b want 0100", out_valid); end
    n_vec++; if (out_data !== 16'hE000) begin n_err++; $display("FAIL arst_pre_data: got %h want e000", out_data); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL arst_valid: got %b want 0000", out_valid); end
    n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL arst_data: got %h want 0000", out_data); end
    n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL arst_count: got %0d want 0", count); end
    n_vec++; if (select !== 2'b00) begin n_err++; $display("FAIL arst_select: got %0d want 0", select); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 4'b1111;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 16'hE001;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 4'b0001) begin n_err++; $display("FAIL arst_post_valid: got %b want 0001", out_valid); end
    n_vec++; if (out_data !== 16'hE001) begin n_err++; $display("FAIL arst_post_data: got %h want e001", out_data); end
    n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL arst_post_count0: got %0d want 0", count); end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_vec++; if (count !== 8'd1) begin n_err++; $display("FAIL arst_post_count1: got %0d want 1", count); end
    n_vec++; if (select !== 2'd1) begin n_err++; $display("FAIL arst_post_select: got %0d want 1", select); end
  endtask

`ifdef DMUX4WAY_RR_SCHED_MASK_EN
  task automatic test_mask();
    logic [3:0] exp_v;
    @(negedge clock);
    reset_n = 1'b0;
    en_mask = 4'b0101;
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 4'b1111;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clock);
      if (i < 4) begin
        in_valid = 1'b1;
        in_data  = 16'hF000 + 16'(i);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        exp_v = ((i - 1) % 2 == 1) ? 4'b0100 : 4'b0001;
        n_vec++; if (out_valid !== exp_v) begin n_err++; $display("FAIL mask_valid[%0d]: got %b want %b", i, out_valid, exp_v); end
      end
      @(posedge clock);
    end
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = 16'hF100;
    out_ready = 4'b0000;
    @(posedge clock);
    @(negedge clock);
    en_mask = 4'b0000;
    in_data = 16'hF101;
    #1;
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL mask_zero_valid: got %b want 0000", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mask_zero_in_ready: got %b want 0", in_ready); end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_vec++; if (select !== 2'b00) begin n_err++; $display("FAIL mask_zero_select: got %0d want 0", select); end
    n_vec++; if (count !== 8'd4) begin n_err++; $display("FAIL mask_zero_count: got %0d want 4", count); end
    n_vec++; if (out_data !== 16'hF100) begin n_err++; $display("FAIL mask_zero_data: got %h want f100", out_data); end
    in_valid  = 1'b0;
    en_mask   = 4'b1111;
    out_ready = 4'b1111;
    @(posedge clock);
  endtask
`endif

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 4'b0000;
`ifdef DMUX4WAY_RR_SCHED_MASK_EN
    en_mask   = 4'b1111;
`endif
    test_reset();
    test_in_order();
    test_stall();
    test_back_to_back();
    test_async_reset();
`ifdef DMUX4WAY_RR_SCHED_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
